// File: rtl/inst_fetch_pkg.sv
`default_nettype none
// ============================================================================
// inst_fetch_pkg : shared widths, bus types and FSM encoding for the fetch stage
// Revision 1.0
// ============================================================================
package inst_fetch_pkg;

    localparam int INST_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int BPB_PKT_W = 34;

    typedef logic [INST_W-1:0]    inst_t;
    typedef logic [ADDR_W-1:0]    addr_t;
    typedef logic [BPB_PKT_W-1:0] bpb_pkt_t;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2
    } fetch_state_e;

    // The I-cache always returns a naturally aligned 8-byte pair.
    function automatic addr_t fetch_align(input addr_t a);
        return {a[ADDR_W-1:3], 3'b000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fetch_if.sv
`default_nettype none
// ============================================================================
// inst_fetch_if : I-cache request/response and instruction-buffer write bundle
// Revision 1.0
// ============================================================================
interface inst_fetch_if;
    import inst_fetch_pkg::*;

    logic     inst_req;
    addr_t    inst_addr;
    logic     inst_addr_ok;
    logic     [63:0] inst_rdata;
    logic     inst_data_ok;
    logic     pred_taken1;
    logic     pred_taken2;
    addr_t    pred_target;
    bpb_pkt_t pred_pkt1;
    bpb_pkt_t pred_pkt2;

    logic     instbuffer_full;
    inst_t    inst_o1;
    inst_t    inst_o2;
    addr_t    inst_addr_o1;
    addr_t    inst_addr_o2;
    logic     inst_valid1;
    logic     inst_valid2;
    bpb_pkt_t predict_pkt1;
    bpb_pkt_t predict_pkt2;

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_rdata, inst_data_ok,
        input  pred_taken1, pred_taken2, pred_target, pred_pkt1, pred_pkt2,
        input  instbuffer_full,
        output inst_o1, inst_o2, inst_addr_o1, inst_addr_o2,
        output inst_valid1, inst_valid2, predict_pkt1, predict_pkt2
    );

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_rdata, inst_data_ok,
        output pred_taken1, pred_taken2, pred_target, pred_pkt1, pred_pkt2,
        output instbuffer_full,
        input  inst_o1, inst_o2, inst_addr_o1, inst_addr_o2,
        input  inst_valid1, inst_valid2, predict_pkt1, predict_pkt2
    );

endinterface
`default_nettype wire

// File: rtl/inst_fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// fetch_pc_gen : next-PC, delay-slot tracking and slot-valid selection
// Revision 1.0
// ============================================================================
module fetch_pc_gen
    import inst_fetch_pkg::*;
(
    input  addr_t pc,
    input  logic  ds_pending,
    input  addr_t ds_target,
    input  logic  accept,
    input  logic  pred_taken1,
    input  logic  pred_taken2,
    input  addr_t pred_target,
    input  logic  flush,
    input  addr_t flush_pc,
    output addr_t pc_next,
    output logic  ds_pending_next,
    output addr_t ds_target_next,
    output logic  slot1_valid,
    output logic  slot2_valid
);

    always_comb begin
        pc_next         = pc;
        ds_pending_next = ds_pending;
        ds_target_next  = ds_target;
        slot1_valid     = 1'b0;
        slot2_valid     = 1'b0;

        if (flush) begin
            pc_next         = flush_pc;
            ds_pending_next = 1'b0;
        end else if (accept) begin
            slot1_valid = 1'b1;
            if (ds_pending) begin
                // Delay-slot fetch: keep only the slot, then jump to the saved target.
                pc_next         = ds_target;
                ds_pending_next = 1'b0;
            end else if (!pc[2]) begin
                slot2_valid = 1'b1;
                pc_next     = pc + 32'd8;
                if (pred_taken1) begin
                    pc_next = pred_target;
                end else if (pred_taken2) begin
                    ds_pending_next = 1'b1;
                    ds_target_next  = pred_target;
                end
            end else begin
                pc_next = pc + 32'd4;
                if (pred_taken1) begin
                    ds_pending_next = 1'b1;
                    ds_target_next  = pred_target;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// inst_fetch : dual-issue fetch stage, owns the PC and feeds the instruction buffer
// Revision 1.0
// ============================================================================
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter addr_t RESET_PC = 32'hBFC0_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  addr_t        flush_pc,
    inst_fetch_if.master bus
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;
    addr_t        r_pc;
    addr_t        r_ds_target;
    logic         r_ds_pending;
    logic         r_discard;

    logic         w_launch;
    logic         w_accept;
    logic         w_data_ok_wait;
    addr_t        w_pc_next;
    addr_t        w_ds_target_next;
    logic         w_ds_pending_next;
    logic         w_slot1_valid;
    logic         w_slot2_valid;

    logic         r_inst_req;
    addr_t        r_inst_addr;
    inst_t        r_inst_o1;
    inst_t        r_inst_o2;
    addr_t        r_inst_addr_o1;
    addr_t        r_inst_addr_o2;
    logic         r_inst_valid1;
    logic         r_inst_valid2;
    bpb_pkt_t     r_predict_pkt1;
    bpb_pkt_t     r_predict_pkt2;

    assign w_data_ok_wait = (r_state == FETCH_WAIT) && bus.inst_data_ok;

    always_comb begin
        w_state_next = r_state;
        w_launch     = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            FETCH_IDLE: begin
                if (!bus.instbuffer_full) begin
                    w_state_next = FETCH_REQ;
                    w_launch     = 1'b1;
                end
            end
            FETCH_REQ: begin
                if (bus.inst_addr_ok) begin
                    w_state_next = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (bus.inst_data_ok) begin
                    w_accept = !r_discard;
                    if (!bus.instbuffer_full) begin
                        w_state_next = FETCH_REQ;
                        w_launch     = 1'b1;
                    end else begin
                        w_state_next = FETCH_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = FETCH_IDLE;
            end
        endcase
    end

    fetch_pc_gen u_pc_gen (
        .pc              (r_pc),
        .ds_pending      (r_ds_pending),
        .ds_target       (r_ds_target),
        .accept          (w_accept),
        .pred_taken1     (bus.pred_taken1),
        .pred_taken2     (bus.pred_taken2),
        .pred_target     (bus.pred_target),
        .flush           (flush),
        .flush_pc        (flush_pc),
        .pc_next         (w_pc_next),
        .ds_pending_next (w_ds_pending_next),
        .ds_target_next  (w_ds_target_next),
        .slot1_valid     (w_slot1_valid),
        .slot2_valid     (w_slot2_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= FETCH_IDLE;
            r_pc         <= RESET_PC;
            r_ds_pending <= 1'b0;
            r_ds_target  <= '0;
            r_discard    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_ds_pending <= w_ds_pending_next;
            r_ds_target  <= w_ds_target_next;
            // A response still owed for the old stream must be dropped when it lands.
            if (flush && ((r_state == FETCH_REQ) ||
                          ((r_state == FETCH_WAIT) && !bus.inst_data_ok))) begin
                r_discard <= 1'b1;
            end else if (w_data_ok_wait) begin
                r_discard <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst_req     <= 1'b0;
            r_inst_addr    <= '0;
            r_inst_o1      <= '0;
            r_inst_o2      <= '0;
            r_inst_addr_o1 <= '0;
            r_inst_addr_o2 <= '0;
            r_inst_valid1  <= 1'b0;
            r_inst_valid2  <= 1'b0;
            r_predict_pkt1 <= '0;
            r_predict_pkt2 <= '0;
        end else begin
            r_inst_req    <= (w_state_next == FETCH_REQ);
            r_inst_valid1 <= w_slot1_valid;
            r_inst_valid2 <= w_slot2_valid;
            // Address is captured only at launch so a flush never alters a held request.
            if (w_launch) begin
                r_inst_addr <= fetch_align(w_pc_next);
            end
            if (w_slot1_valid) begin
                r_inst_o1      <= r_pc[2] ? bus.inst_rdata[63:32] : bus.inst_rdata[31:0];
                r_inst_addr_o1 <= r_pc;
                r_predict_pkt1 <= bus.pred_pkt1;
            end
            if (w_slot2_valid) begin
                r_inst_o2      <= bus.inst_rdata[63:32];
                r_inst_addr_o2 <= r_pc + 32'd4;
                r_predict_pkt2 <= bus.pred_pkt2;
            end
        end
    end

    assign bus.inst_req     = r_inst_req;
    assign bus.inst_addr    = r_inst_addr;
    assign bus.inst_o1      = r_inst_o1;
    assign bus.inst_o2      = r_inst_o2;
    assign bus.inst_addr_o1 = r_inst_addr_o1;
    assign bus.inst_addr_o2 = r_inst_addr_o2;
    assign bus.inst_valid1  = r_inst_valid1;
    assign bus.inst_valid2  = r_inst_valid2;
    assign bus.predict_pkt1 = r_predict_pkt1;
    assign bus.predict_pkt2 = r_predict_pkt2;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// tb_inst_fetch : directed bench with an I-cache responder and a fetch-order model
// Revision 1.0
// ============================================================================
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam addr_t RESET_PC = 32'hBFC0_0000;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  flush = 1'b0;
    addr_t flush_pc = '0;

    inst_fetch_if bus();

    inst_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .flush_pc (flush_pc),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // model of the architectural fetch stream
    addr_t m_pc = RESET_PC;
    bit    m_ds = 1'b0;
    addr_t m_tgt = '0;
    bit    m_discard = 1'b0;

    // cache responder and stimulus knobs
    bit    outstanding = 1'b0;
    int    cnt = 0;
    int    data_lat = 1;
    addr_t req_addr = '0;
    bit    flush_req = 1'b0;
    bit    flush_at_dok = 1'b0;
    int    fl_cyc = -1;
    bit    full_v = 1'b0;
    addr_t f_pc = '0;
    addr_t pt_addr = '0;
    bit    pt1 = 1'b0;
    bit    pt2 = 1'b0;
    addr_t ptgt = '0;

    // expected outputs for the next edge
    bit       exp_v1 = 1'b0, exp_v2 = 1'b0;
    addr_t    exp_a1, exp_a2;
    inst_t    exp_d1, exp_d2;
    bpb_pkt_t exp_p1, exp_p2;

    typedef struct { addr_t a1; logic v2; int c; } ev_t;
    ev_t   ev_q[$];
    addr_t acc_q[$];
    int    acc_cyc_q[$];
    bit    prev_req = 1'b0;
    addr_t prev_addr = '0;
    int    rise_cyc = -1;
    int    rise_cnt = 0;

    function automatic inst_t word_at(input addr_t a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    function automatic bpb_pkt_t pkt_of(input logic [1:0] slot, input addr_t a);
        return {slot, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // compare process: every cycle, #1 after the edge
    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst) begin
            chk("rst_inst_req", 64'(bus.inst_req), 64'd0);
            chk("rst_inst_addr", 64'(bus.inst_addr), 64'd0);
            chk("rst_valid1", 64'(bus.inst_valid1), 64'd0);
            chk("rst_valid2", 64'(bus.inst_valid2), 64'd0);
            chk("rst_inst_o1", 64'(bus.inst_o1), 64'd0);
            chk("rst_pkt1", 64'(bus.predict_pkt1), 64'd0);
            prev_req  = 1'b0;
            prev_addr = '0;
        end else begin
            chk("valid1", 64'(bus.inst_valid1), 64'(exp_v1));
            chk("valid2", 64'(bus.inst_valid2), 64'(exp_v2));
            if (exp_v1) begin
                chk("addr_o1", 64'(bus.inst_addr_o1), 64'(exp_a1));
                chk("inst_o1", 64'(bus.inst_o1), 64'(exp_d1));
                chk("pkt1", 64'(bus.predict_pkt1), 64'(exp_p1));
            end
            if (exp_v2) begin
                chk("addr_o2", 64'(bus.inst_addr_o2), 64'(exp_a2));
                chk("inst_o2", 64'(bus.inst_o2), 64'(exp_d2));
                chk("pkt2", 64'(bus.predict_pkt2), 64'(exp_p2));
            end
            if (bus.inst_valid1)
                ev_q.push_back('{a1: bus.inst_addr_o1, v2: bus.inst_valid2, c: cyc});
            chk("one_outstanding", 64'(bus.inst_req && outstanding), 64'd0);
            if (bus.inst_req && !prev_req) begin
                chk("req_addr", 64'(bus.inst_addr), 64'(fetch_align(m_pc)));
                chk("req_launch_not_full", 64'(bus.instbuffer_full), 64'd0);
                rise_cyc = cyc;
                rise_cnt++;
            end else if (bus.inst_req && prev_req) begin
                chk("req_hold", 64'(bus.inst_addr), 64'(prev_addr));
            end
            prev_req  = bus.inst_req;
            prev_addr = bus.inst_addr;
        end
    end

    // one clock of stimulus: cache responder, flush, full, and model update
    task automatic cycle();
        bit    aok, dok, fl, t1, t2;
        addr_t p;
        @(posedge clk);
        #2;
        aok = 1'b0;
        dok = 1'b0;
        exp_v1 = 1'b0;
        exp_v2 = 1'b0;
        if (outstanding) begin
            if (cnt <= 1) dok = 1'b1;
            else cnt--;
        end
        aok = !rst && bus.inst_req && !outstanding;
        fl  = !rst && (flush_req || (flush_at_dok && dok));
        if (fl) begin
            flush_req    = 1'b0;
            flush_at_dok = 1'b0;
            fl_cyc       = cyc;
        end
        t1 = dok && (req_addr == pt_addr) && pt1;
        t2 = dok && (req_addr == pt_addr) && pt2;
        bus.inst_rdata   = dok ? {word_at(req_addr + 32'd4), word_at(req_addr)} : 64'd0;
        bus.pred_taken1  = t1;
        bus.pred_taken2  = t2;
        bus.pred_target  = dok ? ptgt : '0;
        bus.pred_pkt1    = dok ? pkt_of(2'b01, req_addr) : '0;
        bus.pred_pkt2    = dok ? pkt_of(2'b10, req_addr) : '0;
        if (dok) begin
            if (!fl && !m_discard) begin
                p      = m_pc;
                exp_v1 = 1'b1;
                exp_a1 = p;
                exp_d1 = word_at(p);
                exp_p1 = pkt_of(2'b01, req_addr);
                exp_a2 = p + 32'd4;
                exp_d2 = word_at(p + 32'd4);
                exp_p2 = pkt_of(2'b10, req_addr);
                if (m_ds) begin
                    m_pc = m_tgt;
                    m_ds = 1'b0;
                end else if (!p[2]) begin
                    exp_v2 = 1'b1;
                    m_pc   = t1 ? ptgt : p + 32'd8;
                    if (!t1 && t2) begin m_ds = 1'b1; m_tgt = ptgt; end
                end else begin
                    m_pc = p + 32'd4;
                    if (t1) begin m_ds = 1'b1; m_tgt = ptgt; end
                end
            end
            m_discard   = 1'b0;
            outstanding = 1'b0;
        end else if (fl && (bus.inst_req || outstanding)) begin
            m_discard = 1'b1;
        end
        if (fl) begin
            m_pc = f_pc;
            m_ds = 1'b0;
        end
        if (aok) begin
            outstanding = 1'b1;
            cnt         = data_lat;
            req_addr    = bus.inst_addr;
            acc_q.push_back(bus.inst_addr);
            acc_cyc_q.push_back(cyc);
        end
        bus.inst_addr_ok    = aok;
        bus.inst_data_ok    = dok;
        bus.instbuffer_full = full_v;
        flush               = fl;
        flush_pc            = f_pc;
    endtask

    task automatic clear_logs();
        ev_q.delete();
        acc_q.delete();
        acc_cyc_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int    rel, idx, rc0, drop;
        bit    found;
        bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = '0;
        bus.pred_taken1 = 1'b0; bus.pred_taken2 = 1'b0; bus.pred_target = '0;
        bus.pred_pkt1 = '0; bus.pred_pkt2 = '0; bus.instbuffer_full = 1'b0;

        // reset and back-to-back stream
        repeat (3) cycle();
        rst = 1'b0;
        rel = cyc;
        repeat (8) cycle();
        chk("first_req_cycle", 64'(acc_cyc_q[0]), 64'(rel + 1));
        chk("stream_addr0", 64'(acc_q[0]), 64'h0000_0000_BFC0_0000);
        chk("stream_addr1", 64'(acc_q[1]), 64'h0000_0000_BFC0_0008);
        chk("stream_addr2", 64'(acc_q[2]), 64'h0000_0000_BFC0_0010);
        chk("stream_cadence", 64'(acc_cyc_q[1] - acc_cyc_q[0]), 64'd2);
        chk("stream_ev0_addr", 64'(ev_q[0].a1), 64'h0000_0000_BFC0_0000);
        chk("stream_ev0_pair", 64'(ev_q[0].v2), 64'd1);
        chk("stream_ev_spacing", 64'(ev_q[1].c - ev_q[0].c), 64'd2);

        // misaligned redirect
        clear_logs();
        f_pc = 32'h8000_0184; flush_req = 1'b1;
        repeat (10) cycle();
        found = 1'b0; idx = 0;
        foreach (acc_q[i]) if (!found && acc_q[i] == 32'h8000_0180) begin found = 1'b1; idx = i; end
        chk("mis_req_found", 64'(found), 64'd1);
        if (found && idx + 1 < acc_q.size())
            chk("mis_next_req", 64'(acc_q[idx+1]), 64'h0000_0000_8000_0188);
        found = 1'b0;
        foreach (ev_q[i]) if (!found && ev_q[i].a1 == 32'h8000_0184) begin found = 1'b1; idx = i; end
        chk("mis_ev_found", 64'(found), 64'd1);
        if (found) chk("mis_slot2_invalid", 64'(ev_q[idx].v2), 64'd0);

        // taken branch in slot 2: delay slot then target
        clear_logs();
        pt_addr = 32'h8000_1000; pt1 = 1'b0; pt2 = 1'b1; ptgt = 32'h8000_2000;
        f_pc = 32'h8000_1000; flush_req = 1'b1;
        repeat (12) cycle();
        found = 1'b0; idx = 0;
        foreach (acc_q[i]) if (!found && acc_q[i] == 32'h8000_1000) begin found = 1'b1; idx = i; end
        chk("br_req_found", 64'(found), 64'd1);
        if (found && idx + 2 < acc_q.size()) begin
            chk("br_delay_req", 64'(acc_q[idx+1]), 64'h0000_0000_8000_1008);
            chk("br_target_req", 64'(acc_q[idx+2]), 64'h0000_0000_8000_2000);
        end
        found = 1'b0;
        foreach (ev_q[i]) if (!found && ev_q[i].a1 == 32'h8000_1008) begin found = 1'b1; idx = i; end
        chk("br_ds_ev_found", 64'(found), 64'd1);
        if (found) chk("br_ds_slot2_invalid", 64'(ev_q[idx].v2), 64'd0);
        pt2 = 1'b0;

        // flush while waiting for data
        data_lat = 3;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (outstanding && cnt == data_lat) begin found = 1'b1; break; end
        end
        chk("wait_state_reached", 64'(found), 64'd1);
        clear_logs();
        f_pc = 32'h8000_3000; flush_req = 1'b1;
        repeat (12) cycle();
        chk("wflush_first_req", 64'(acc_q.size() > 0 ? acc_q[0] : 32'h0), 64'h0000_0000_8000_3000);
        chk("wflush_first_ev", 64'(ev_q.size() > 0 ? ev_q[0].a1 : 32'h0), 64'h0000_0000_8000_3000);
        data_lat = 1;

        // flush coinciding with data_ok
        clear_logs();
        f_pc = 32'h8000_4000; flush_at_dok = 1'b1;
        repeat (10) cycle();
        chk("dflush_first_ev", 64'(ev_q.size() > 0 ? ev_q[0].a1 : 32'h0), 64'h0000_0000_8000_4000);
        found = 1'b0;
        foreach (acc_q[i]) if (!found && acc_cyc_q[i] > fl_cyc) begin found = 1'b1; idx = i; end
        chk("dflush_req_found", 64'(found), 64'd1);
        if (found) chk("dflush_next_req", 64'(acc_q[idx]), 64'h0000_0000_8000_4000);

        // buffer full for 5 cycles
        clear_logs();
        full_v = 1'b1;
        cycle();
        rc0 = rise_cnt;
        repeat (4) cycle();
        full_v = 1'b0;
        cycle();
        drop = cyc;
        chk("full_no_launch", 64'(rise_cnt - rc0), 64'd0);
        chk("full_inflight_written", 64'(ev_q.size() != 0), 64'd1);
        cycle();
        chk("full_resume_cycle", 64'(rise_cyc), 64'(drop + 1));
        repeat (6) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_fetch.md
# inst_fetch

Dual-issue fetch stage that sits directly upstream of the instruction buffer. It owns the PC and issues one 8-byte-aligned fetch request at a time to the I-cache over a request/addr_ok/data_ok handshake. It pairs each returned instruction with its address and BPB prediction packet and writes up to two instructions per cycle into the buffer. It handles misaligned PCs, predicted-taken branches including MIPS delay slots, buffer back-pressure, and flush redirection.

## Interface
Parameters:
- RESET_PC, 32'hBFC00000: PC loaded on reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset (`RstEnable`)
- flush  in  1  redirect request (exception or mispredict)
- flush_pc  in  `InstAddrBus`  redirect target
- instbuffer_full  in  1  buffer back-pressure
- inst_req  out  1  I-cache request
- inst_addr  out  `InstAddrBus`  request address, {pc[31:3],3'b000}
- inst_addr_ok  in  1  request accepted
- inst_rdata  in  64  [31:0] is the word at +0, [63:32] is the word at +4
- inst_data_ok  in  1  read data valid
- pred_taken1, pred_taken2  in  1 each  BPB taken prediction for output slot 1/2, valid with inst_data_ok
- pred_target  in  `InstAddrBus`  target of the taken slot
- pred_pkt1, pred_pkt2  in  `BPBPacketWidth` each  prediction packets, valid with inst_data_ok
- inst_o1, inst_o2  out  `InstBus`  instructions to buffer
- inst_addr_o1, inst_addr_o2  out  `InstAddrBus`  their addresses
- inst_valid1, inst_valid2  out  1 each  write enables
- predict_pkt1, predict_pkt2  out  `BPBPacketWidth` each  packets to buffer

## Operation
- FSM states: IDLE, REQ, WAIT.
  - IDLE → REQ when !instbuffer_full.
  - REQ: inst_req=1. Go to WAIT on inst_addr_ok.
  - WAIT: on inst_data_ok, go to REQ if !instbuffer_full (sampled that cycle), else IDLE.
- Protocol: inst_req and inst_addr hold until inst_addr_ok. A request is never withdrawn. Only one request is outstanding.
- Slot selection on data_ok:
  - pc[2]=0: slot1=rdata[31:0] at pc, slot2=rdata[63:32] at pc+4, both valid. Default next pc = pc+8.
  - pc[2]=1: slot1=rdata[63:32] at pc, slot2 invalid. Default next pc = pc+4.
  - ds_pending=1 (delay-slot fetch): slot2 is forced invalid. Next pc = saved target. ds_pending clears.
- Branch handling:
  - Taken branch in slot1 with slot2 valid: slot2 is the delay slot. Next pc = pred_target.
  - Taken branch in the last valid slot (slot2, or slot1 when pc[2]=1): next pc = default. Save pred_target and set ds_pending.
  - pred_taken on an invalid slot is ignored.
- Flush in REQ or WAIT:
  - pc ← flush_pc; ds_pending ← 0; discard ← 1.
  - If in REQ, the held request completes as normal.
  - The next inst_data_ok is dropped (no valid outputs) and clears discard.
  - The FSM then fetches from flush_pc.
- Flush in IDLE: pc ← flush_pc only.
- Flush on the same cycle as inst_data_ok: the data is dropped and pc ← flush_pc. discard is not set, because that response is already consumed.
- Flush has priority over every branch update.

## Timing
- Reset: state=IDLE, pc=RESET_PC, ds_pending=0, discard=0. All outputs 0, including inst_req and inst_addr.
- Outputs are registered. inst_valid* pulses for exactly one cycle, in the cycle after inst_data_ok. It is 0 in all other cycles.
- Best cadence with zero-latency cache: REQ (addr_ok) → WAIT (data_ok) → REQ, i.e. 2 instructions every 2 cycles.
- First inst_req after reset: 2nd cycle (IDLE, then REQ).
- Reset mid-transaction abandons all state. The I-cache is reset on the same edge.
- instbuffer_full is honoured only at request launch. Data already in flight is always written, because the buffer keeps ≥7 free entries when not full.

## Structure
- defines.v already holds InstBus, InstAddrBus, BPBPacketWidth, RstEnable, Valid/Invalid. Add the FSM state encodings (FetchIdle/FetchReq/FetchWait) there.
- One combinational sub-module, fetch_pc_gen, covers:
  - inputs: pc, ds_pending, saved target, pred_taken1/2, pred_target, flush, flush_pc
  - outputs: next pc, new ds_pending, slot valids
- FSM, handshake, and output registers stay in inst_fetch.

## Test plan
- Reset, cache returns addr_ok/data_ok immediately:
  - inst_addr sequence BFC00000, BFC00008, BFC00010.
  - Valid pairs arrive every 2 cycles with addresses pc/pc+4.
- flush_pc=80000184 (pc[2]=1):
  - Request addr 80000180. Only inst_valid1=1, with inst_addr_o1=80000184.
  - Next request 80000188.
- pred_taken2 at 80001000, target 80002000:
  - Next fetch 80001008 with only slot1 valid (delay slot).
  - Then 80002000.
- Flush while in WAIT:
  - The pending data_ok produces no valid outputs.
  - The next request is at flush_pc.
- Flush on the same cycle as data_ok: outputs stay invalid; the next request is at flush_pc.
- instbuffer_full=1 held for 5 cycles: inst_req stays 0 after the in-flight data is written. The request resumes the cycle after full drops.
